// File: rtl/dram_arbiter.sv
// Two-requester arbiter (instruction fetch, MEM stage) for a single synchronous-read data RAM.
// MEM has priority; a starvation counter lets IF win a conflict after STARVE_MAX waiting cycles.
module dram_arbiter #(
  parameter int STARVE_MAX = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  input  logic        if_cancel,
  output logic        if_gnt,
  output logic        if_rvalid,
  output logic [31:0] if_rdata,
  input  logic        mem_req,
  input  logic [3:0]  mem_wen,
  input  logic [31:0] mem_addr,
  input  logic [31:0] mem_wdata,
  output logic        mem_gnt,
  output logic        mem_rvalid,
  output logic [31:0] mem_rdata,
  output logic [31:0] ram_addr,
  output logic [3:0]  ram_wen,
  output logic [31:0] ram_wdata,
  input  logic [31:0] ram_rdata
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RD_IF  = 2'd1,
    RD_MEM = 2'd2
  } owner_e;

  localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

  owner_e     rd_owner_q, rd_owner_d;
  logic [3:0] starve_cnt_q, starve_cnt_d;

  // Grant selection: MEM wins a conflict unless IF has waited STARVE_MAX cycles.
  always_comb begin
    if_gnt  = 1'b0;
    mem_gnt = 1'b0;
    if (rst) begin
      if_gnt  = 1'b0;
      mem_gnt = 1'b0;
    end else if (if_req && (!mem_req || (starve_cnt_q == STARVE_LIM))) begin
      if_gnt  = 1'b1;
    end else if (mem_req) begin
      mem_gnt = 1'b1;
    end else begin
      if_gnt  = 1'b0;
      mem_gnt = 1'b0;
    end
  end

  // RAM port drive from the granted requester; idle port is all-zero.
  always_comb begin
    ram_addr  = 32'h0000_0000;
    ram_wen   = 4'b0000;
    ram_wdata = 32'h0000_0000;
    if (if_gnt) begin
      ram_addr  = if_addr;
    end else if (mem_gnt) begin
      ram_addr  = mem_addr;
      ram_wen   = mem_wen;
      ram_wdata = mem_wdata;
    end else begin
      ram_addr  = 32'h0000_0000;
      ram_wen   = 4'b0000;
      ram_wdata = 32'h0000_0000;
    end
  end

  // Next-state for the starvation counter and the read-owner tag of the returning data.
  always_comb begin
    starve_cnt_d = 4'd0;
    rd_owner_d   = IDLE;
    if (if_req && !if_gnt) begin
      starve_cnt_d = (starve_cnt_q == STARVE_LIM) ? starve_cnt_q : starve_cnt_q + 4'd1;
    end else begin
      starve_cnt_d = 4'd0;
    end
    if (if_gnt && !if_cancel) begin
      rd_owner_d = RD_IF;
    end else if (mem_gnt && (mem_wen == 4'b0000)) begin
      rd_owner_d = RD_MEM;
    end else begin
      rd_owner_d = IDLE;
    end
  end

  // Response routing; a cancel in the return cycle drops the IF data.
  always_comb begin
    if_rvalid  = 1'b0;
    mem_rvalid = 1'b0;
    if (rst) begin
      if_rvalid  = 1'b0;
      mem_rvalid = 1'b0;
    end else begin
      if_rvalid  = (rd_owner_q == RD_IF) && !if_cancel;
      mem_rvalid = (rd_owner_q == RD_MEM);
    end
  end

  assign if_rdata  = ram_rdata;
  assign mem_rdata = ram_rdata;

  // Owner FSM and starvation counter state.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_owner_q   <= IDLE;
      starve_cnt_q <= 4'd0;
    end else begin
      rd_owner_q   <= rd_owner_d;
      starve_cnt_q <= starve_cnt_d;
    end
  end

endmodule

// File: tb/tb_dram_arbiter.sv
// Directed bench for dram_arbiter with a small synchronous-read RAM model behind the RAM port.
module tb_dram_arbiter;

  logic        clk = 1'b0;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_cancel;
  logic        if_gnt;
  logic        if_rvalid;
  logic [31:0] if_rdata;
  logic        mem_req;
  logic [3:0]  mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic        mem_gnt;
  logic        mem_rvalid;
  logic [31:0] mem_rdata;
  logic [31:0] ram_addr;
  logic [3:0]  ram_wen;
  logic [31:0] ram_wdata;
  logic [31:0] ram_rdata = 32'h0000_0000;

  logic [31:0] ram_mem [0:255];
  int vec_cnt = 0;
  int err_cnt = 0;

  dram_arbiter #(.STARVE_MAX(4)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr), .if_cancel(if_cancel),
    .if_gnt(if_gnt), .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .mem_req(mem_req), .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_gnt(mem_gnt), .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata),
    .ram_addr(ram_addr), .ram_wen(ram_wen), .ram_wdata(ram_wdata), .ram_rdata(ram_rdata)
  );

  always #5 clk = ~clk;

  // RAM model: byte-enabled write, read data one cycle after the address.
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (ram_wen[b]) ram_mem[ram_addr[9:2]][8*b +: 8] <= ram_wdata[8*b +: 8];
    end
    ram_rdata <= ram_mem[ram_addr[9:2]];
  end

  task automatic chk_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vec_cnt++;
    if (got !== exp) begin
      err_cnt++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic next_cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_idle();
    if_req    = 1'b0;
    if_addr   = 32'h0000_0000;
    if_cancel = 1'b0;
    mem_req   = 1'b0;
    mem_wen   = 4'b0000;
    mem_addr  = 32'h0000_0000;
    mem_wdata = 32'h0000_0000;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) ram_mem[i] = 32'h0000_0000;
    ram_mem[64] = 32'hDEAD_BEEF;
    ram_mem[2]  = 32'h1122_3344;

    // Reset for two cycles with both requests pending: nothing may be granted.
    drive_idle();
    rst     = 1'b1;
    if_req  = 1'b1;
    mem_req = 1'b1;
    @(negedge clk);
    chk_vec("rst_if_gnt",  {31'd0, if_gnt},  32'd0);
    chk_vec("rst_mem_gnt", {31'd0, mem_gnt}, 32'd0);
    chk_vec("rst_ram_wen", {28'd0, ram_wen}, 32'd0);
    @(posedge clk);
    next_cyc();
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    chk_vec("idle_if_gnt",     {31'd0, if_gnt},     32'd0);
    chk_vec("idle_mem_gnt",    {31'd0, mem_gnt},    32'd0);
    chk_vec("idle_if_rvalid",  {31'd0, if_rvalid},  32'd0);
    chk_vec("idle_mem_rvalid", {31'd0, mem_rvalid}, 32'd0);
    chk_vec("idle_ram_wen",    {28'd0, ram_wen},    32'd0);
    chk_vec("idle_ram_addr",   ram_addr,            32'h0000_0000);
    next_cyc();

    // Single IF read.
    if_req  = 1'b1;
    if_addr = 32'h0000_0100;
    @(negedge clk);
    chk_vec("if_gnt",      {31'd0, if_gnt},  32'd1);
    chk_vec("if_ram_addr", ram_addr,         32'h0000_0100);
    chk_vec("if_ram_wen",  {28'd0, ram_wen}, 32'd0);
    next_cyc();
    drive_idle();
    @(negedge clk);
    chk_vec("if_rvalid",     {31'd0, if_rvalid},  32'd1);
    chk_vec("if_rdata",      if_rdata,            32'hDEAD_BEEF);
    chk_vec("if_mem_rvalid", {31'd0, mem_rvalid}, 32'd0);
    next_cyc();

    // Byte store into lane 2, then load it back.
    mem_req   = 1'b1;
    mem_wen   = 4'b0100;
    mem_addr  = 32'h0000_0008;
    mem_wdata = 32'h00AB_0000;
    @(negedge clk);
    chk_vec("st_mem_gnt",   {31'd0, mem_gnt}, 32'd1);
    chk_vec("st_if_gnt",    {31'd0, if_gnt},  32'd0);
    chk_vec("st_ram_wen",   {28'd0, ram_wen}, 32'h0000_0004);
    chk_vec("st_ram_wdata", ram_wdata,        32'h00AB_0000);
    chk_vec("st_ram_addr",  ram_addr,         32'h0000_0008);
    next_cyc();
    drive_idle();
    @(negedge clk);
    chk_vec("st_no_rvalid", {31'd0, mem_rvalid}, 32'd0);
    next_cyc();
    mem_req  = 1'b1;
    mem_addr = 32'h0000_0008;
    @(negedge clk);
    chk_vec("ld_mem_gnt", {31'd0, mem_gnt}, 32'd1);
    chk_vec("ld_ram_wen", {28'd0, ram_wen}, 32'd0);
    next_cyc();
    drive_idle();
    @(negedge clk);
    chk_vec("ld_mem_rvalid", {31'd0, mem_rvalid}, 32'd1);
    chk_vec("ld_mem_rdata",  mem_rdata,           32'h11AB_3344);
    chk_vec("ld_if_rvalid",  {31'd0, if_rvalid},  32'd0);
    next_cyc();

    // Continuous conflict: MEM x4, IF on the 5th, then MEM again with the counter cleared.
    if_req   = 1'b1;
    if_addr  = 32'h0000_0100;
    mem_req  = 1'b1;
    mem_addr = 32'h0000_0008;
    for (int k = 1; k <= 7; k++) begin
      @(negedge clk);
      chk_vec($sformatf("conf%0d_if_gnt", k),     {31'd0, if_gnt},     {31'd0, k == 5});
      chk_vec($sformatf("conf%0d_mem_gnt", k),    {31'd0, mem_gnt},    {31'd0, k != 5});
      chk_vec($sformatf("conf%0d_if_rvalid", k),  {31'd0, if_rvalid},  {31'd0, k == 6});
      chk_vec($sformatf("conf%0d_mem_rvalid", k), {31'd0, mem_rvalid}, {31'd0, (k >= 2) && (k != 6)});
      if (k == 6) chk_vec("conf_if_rdata", if_rdata, 32'hDEAD_BEEF);
      if (k == 2) chk_vec("conf_mem_rdata", mem_rdata, 32'h11AB_3344);
      next_cyc();
    end
    drive_idle();
    @(negedge clk);
    chk_vec("conf_tail_mem_rvalid", {31'd0, mem_rvalid}, 32'd1);
    next_cyc();

    // Cancel in the grant cycle: RAM is still read, response dropped; MEM load right behind.
    if_req    = 1'b1;
    if_addr   = 32'h0000_0100;
    if_cancel = 1'b1;
    @(negedge clk);
    chk_vec("cxl_if_gnt",   {31'd0, if_gnt}, 32'd1);
    chk_vec("cxl_ram_addr", ram_addr,        32'h0000_0100);
    next_cyc();
    drive_idle();
    mem_req  = 1'b1;
    mem_addr = 32'h0000_0008;
    @(negedge clk);
    chk_vec("cxl_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    chk_vec("cxl_mem_gnt",   {31'd0, mem_gnt},   32'd1);
    next_cyc();
    drive_idle();
    @(negedge clk);
    chk_vec("cxl_mem_rvalid", {31'd0, mem_rvalid}, 32'd1);
    chk_vec("cxl_mem_rdata",  mem_rdata,           32'h11AB_3344);
    next_cyc();

    // Cancel in the return cycle suppresses an already-granted IF response.
    if_req  = 1'b1;
    if_addr = 32'h0000_0100;
    @(negedge clk);
    chk_vec("cxl2_if_gnt", {31'd0, if_gnt}, 32'd1);
    next_cyc();
    drive_idle();
    if_cancel = 1'b1;
    @(negedge clk);
    chk_vec("cxl2_if_rvalid", {31'd0, if_rvalid}, 32'd0);
    next_cyc();
    if_cancel = 1'b0;
    @(negedge clk);
    chk_vec("cxl2_if_rvalid_after", {31'd0, if_rvalid}, 32'd0);
    next_cyc();

    // Reset in the return cycle of a MEM load drops the response.
    mem_req  = 1'b1;
    mem_addr = 32'h0000_0008;
    @(negedge clk);
    chk_vec("rstld_mem_gnt", {31'd0, mem_gnt}, 32'd1);
    next_cyc();
    rst = 1'b1;
    @(negedge clk);
    chk_vec("rstld_rvalid_n1", {31'd0, mem_rvalid}, 32'd0);
    chk_vec("rstld_gnt_n1",    {31'd0, mem_gnt},    32'd0);
    next_cyc();
    rst = 1'b0;
    drive_idle();
    @(negedge clk);
    chk_vec("rstld_rvalid_n2",    {31'd0, mem_rvalid}, 32'd0);
    chk_vec("rstld_if_rvalid_n2", {31'd0, if_rvalid},  32'd0);
    chk_vec("rstld_ram_addr",     ram_addr,            32'h0000_0000);
    next_cyc();

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

endmodule
